// File: rtl/whack_a_mole_if.sv
// Bundle between the whack-a-mole engine and its surroundings: debounced
// inputs and 1 Hz tick in, LED / display values out.
interface whack_a_mole_if #(
  parameter int NUM_MOLES   = 5,
  parameter int SCORE_WIDTH = 8,
  parameter int GAME_TICKS  = 60
);
  localparam int TIME_W = $clog2(GAME_TICKS + 1);

  logic                   tick;
  logic                   start;
  logic [NUM_MOLES-1:0]   hit_pulse;
  logic [NUM_MOLES-1:0]   mole_active;
  logic [SCORE_WIDTH-1:0] score;
  logic [SCORE_WIDTH-1:0] miss_count;
  logic [TIME_W-1:0]      time_left;
  logic [3:0]             level;
  logic                   game_active;
  logic                   game_over;

  modport master (
    output tick, start, hit_pulse,
    input  mole_active, score, miss_count, time_left, level, game_active, game_over
  );

  modport slave (
    input  tick, start, hit_pulse,
    output mole_active, score, miss_count, time_left, level, game_active, game_over
  );
endinterface

// File: rtl/whack_a_mole_core.sv
// Whack-a-mole game engine: IDLE/PLAY/OVER control, LFSR mole spawning with
// per-mole lifetimes, saturating score and miss counters, and the game timer.
module whack_a_mole_core #(
  parameter int          NUM_MOLES       = 5,
  parameter int          MAX_ACTIVE      = 2,
  parameter int          GAME_TICKS      = 60,
  parameter int          MOLE_LIFE_TICKS = 4,
  parameter int          LEVEL_SHIFT     = 3,
  parameter int          SCORE_WIDTH     = 8,
  parameter bit          WRONG_PENALTY   = 1'b1,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic           clock,
  input  logic           reset,
  whack_a_mole_if.slave  bus
);
  localparam int TIME_W = $clog2(GAME_TICKS + 1);
  localparam int LIFE_W = $clog2(MOLE_LIFE_TICKS + 1);
  localparam int CNT_W  = $clog2(NUM_MOLES + 1);
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t                 state_q, state_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [LIFE_W-1:0]      life_q [NUM_MOLES];
  logic [LIFE_W-1:0]      life_d [NUM_MOLES];
  logic [NUM_MOLES-1:0]   active_q, active_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d, miss_q, miss_d;
  logic [TIME_W-1:0]      time_q, time_d;
  logic [3:0]             level_q, level_d;
  logic                   game_active_q, game_over_q;
  logic [NUM_MOLES-1:0]   good, bad, expire, spawn_sel;
  logic                   final_tick;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_MOLES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_MOLES; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  function automatic logic [SCORE_WIDTH-1:0] sat_add(input logic [SCORE_WIDTH-1:0] a,
                                                     input logic [CNT_W-1:0] b);
    logic [SCORE_WIDTH:0] s;
    s = {1'b0, a} + (SCORE_WIDTH+1)'(b);
    return s[SCORE_WIDTH] ? SCORE_MAX : s[SCORE_WIDTH-1:0];
  endfunction

  function automatic logic [SCORE_WIDTH-1:0] floor_dec(input logic [SCORE_WIDTH-1:0] a);
    return (a == '0) ? a : a - 1'b1;
  endfunction

  function automatic logic [3:0] level_of(input logic [SCORE_WIDTH-1:0] s);
    logic [SCORE_WIDTH-1:0] sh;
    sh = s >> LEVEL_SHIFT;
    return (sh > SCORE_WIDTH'(15)) ? 4'd15 : sh[3:0];
  endfunction

  function automatic logic [LIFE_W-1:0] spawn_life(input logic [3:0] lvl);
    int l;
    l = MOLE_LIFE_TICKS - int'(lvl);
    if (l < 1) l = 1;
    return LIFE_W'(l);
  endfunction

  // Galois form, taps 16,14,13,11 (right shift, feedback mask 0xB400).
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  assign good       = bus.hit_pulse & active_q;
  assign bad        = bus.hit_pulse & ~active_q;
  assign final_tick = bus.tick && (time_q == TIME_W'(1));

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    active_d  = active_q;
    life_d    = life_q;
    score_d   = score_q;
    miss_d    = miss_q;
    time_d    = time_q;
    level_d   = level_q;
    expire    = '0;
    spawn_sel = '0;
    case (state_q)
      IDLE, OVER: begin
        if (bus.start) begin
          state_d  = PLAY;
          score_d  = '0;
          miss_d   = '0;
          level_d  = '0;
          active_d = '0;
          time_d   = TIME_W'(GAME_TICKS);
          for (int i = 0; i < NUM_MOLES; i++) life_d[i] = '0;
        end
      end
      PLAY: begin
        score_d = sat_add(score_q, popcount(good));
        if (WRONG_PENALTY && (bad != '0)) score_d = floor_dec(score_d);
        level_d  = level_of(score_d);
        active_d = active_q & ~good;
        for (int i = 0; i < NUM_MOLES; i++) if (good[i]) life_d[i] = '0;
        if (bus.tick) begin
          lfsr_d = lfsr_step(lfsr_q);
          time_d = time_q - 1'b1;
          if (final_tick) begin
            // Last tick wipes the field without counting misses or spawning.
            state_d  = OVER;
            active_d = '0;
            for (int i = 0; i < NUM_MOLES; i++) life_d[i] = '0;
          end else begin
            for (int i = 0; i < NUM_MOLES; i++) begin
              if (active_q[i] && !good[i]) begin
                life_d[i] = life_q[i] - 1'b1;
                if (life_q[i] == LIFE_W'(1)) begin
                  expire[i]   = 1'b1;
                  active_d[i] = 1'b0;
                end
              end
              spawn_sel[i] = ((int'(lfsr_q[7:0]) % NUM_MOLES) == i);
            end
            miss_d = sat_add(miss_q, popcount(expire));
            // A lit target (hit or expiring included) means no spawn this tick.
            if ((int'(popcount(active_q)) < MAX_ACTIVE) && ((spawn_sel & ~active_q) != '0)) begin
              active_d = active_d | spawn_sel;
              for (int i = 0; i < NUM_MOLES; i++)
                if (spawn_sel[i]) life_d[i] = spawn_life(level_q);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      lfsr_q        <= LFSR_SEED;
      active_q      <= '0;
      score_q       <= '0;
      miss_q        <= '0;
      time_q        <= '0;
      level_q       <= '0;
      game_active_q <= 1'b0;
      game_over_q   <= 1'b0;
      for (int i = 0; i < NUM_MOLES; i++) life_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      active_q      <= active_d;
      score_q       <= score_d;
      miss_q        <= miss_d;
      time_q        <= time_d;
      level_q       <= level_d;
      game_active_q <= (state_d == PLAY);
      game_over_q   <= (state_d == OVER);
      life_q        <= life_d;
    end
  end

  assign bus.mole_active = active_q;
  assign bus.score       = score_q;
  assign bus.miss_count  = miss_q;
  assign bus.time_left   = time_q;
  assign bus.level       = level_q;
  assign bus.game_active = game_active_q;
  assign bus.game_over   = game_over_q;
endmodule

// File: tb/tb_whack_a_mole_core.sv
// Bench for whack_a_mole_core: a per-cycle reference model of the game rules
// plus directed scenarios with hand-computed expectations.
module tb_whack_a_mole_core;
  localparam int N    = 5;
  localparam int MAXA = 2;
  localparam int GAME = 60;
  localparam int LIFE = 4;
  localparam int SMAX = 255;
  localparam int ST_IDLE = 0, ST_PLAY = 1, ST_OVER = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  whack_a_mole_if #(.NUM_MOLES(N), .SCORE_WIDTH(8), .GAME_TICKS(GAME)) bus ();
  whack_a_mole_if #(.NUM_MOLES(8), .SCORE_WIDTH(8), .GAME_TICKS(GAME)) w_bus ();

  whack_a_mole_core #(.NUM_MOLES(N), .MAX_ACTIVE(MAXA)) dut (
    .clock(clk), .reset(rst), .bus(bus)
  );
  whack_a_mole_core #(.NUM_MOLES(8), .MAX_ACTIVE(3)) dut_wide (
    .clock(clk), .reset(rst), .bus(w_bus)
  );

  assign w_bus.tick      = bus.tick;
  assign w_bus.start     = bus.start;
  assign w_bus.hit_pulse = '0;

  int total = 0;
  int bad_n = 0;
  bit chk_en = 1'b0;

  // Reference model state: a mole is lit while its remaining life is > 0.
  int          m_state = ST_IDLE;
  logic [15:0] m_lfsr  = 16'hACE1;
  int          m_life [N];
  int          m_score = 0, m_miss = 0, m_time = 0;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad_n++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, want, want, $time);
    end
  endtask

  function automatic logic [N-1:0] model_mask();
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = (m_life[i] > 0);
    return m;
  endfunction

  function automatic int lvl_of(input int s);
    return ((s >> 3) > 15) ? 15 : (s >> 3);
  endfunction

  function automatic logic [15:0] galois(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [N-1:0] lowest(input logic [N-1:0] m);
    return m & (~m + 1'b1);
  endfunction

  task automatic model_step();
    logic [N-1:0] lit, good, badm;
    int lvl, idx;
    logic [15:0] pre;
    if (rst) begin
      m_state = ST_IDLE; m_lfsr = 16'hACE1;
      m_score = 0; m_miss = 0; m_time = 0;
      for (int i = 0; i < N; i++) m_life[i] = 0;
      return;
    end
    lit = model_mask();
    if (m_state == ST_PLAY) begin
      lvl  = lvl_of(m_score);
      good = bus.hit_pulse & lit;
      badm = bus.hit_pulse & ~lit;
      m_score = m_score + $countones(good);
      if (m_score > SMAX) m_score = SMAX;
      if (badm != '0 && m_score > 0) m_score = m_score - 1;
      for (int i = 0; i < N; i++) if (good[i]) m_life[i] = 0;
      if (bus.tick) begin
        pre = m_lfsr;
        m_lfsr = galois(m_lfsr);
        if (m_time == 1) begin
          m_time = 0; m_state = ST_OVER;
          for (int i = 0; i < N; i++) m_life[i] = 0;
        end else begin
          m_time = m_time - 1;
          for (int i = 0; i < N; i++)
            if (lit[i] && !good[i]) begin
              m_life[i] = m_life[i] - 1;
              if (m_life[i] == 0 && m_miss < SMAX) m_miss = m_miss + 1;
            end
          if ($countones(lit) < MAXA) begin
            idx = int'(pre[7:0]) % N;
            if (!lit[idx]) m_life[idx] = (LIFE - lvl < 1) ? 1 : LIFE - lvl;
          end
        end
      end
    end else if (bus.start) begin
      m_state = ST_PLAY; m_score = 0; m_miss = 0; m_time = GAME;
      for (int i = 0; i < N; i++) m_life[i] = 0;
    end
  endtask

  // Outputs are compared mid-cycle, then the model consumes the inputs
  // that the next rising edge will sample.
  always @(negedge clk) begin
    if (chk_en) begin
      check("mole_active", int'(bus.mole_active), int'(model_mask()));
      check("score", int'(bus.score), m_score);
      check("miss_count", int'(bus.miss_count), m_miss);
      check("time_left", int'(bus.time_left), m_time);
      check("level", int'(bus.level), lvl_of(m_score));
      check("game_active", int'(bus.game_active), int'(m_state == ST_PLAY));
      check("game_over", int'(bus.game_over), int'(m_state == ST_OVER));
      if (w_bus.game_active)
        check("wide_pop_le_3", int'($countones(w_bus.mole_active) <= 3), 1);
    end
    model_step();
  end

  task automatic drive(input bit t, input bit s, input logic [N-1:0] h);
    bus.tick = t; bus.start = s; bus.hit_pulse = h;
    @(posedge clk); #1;
    bus.tick = 1'b0; bus.start = 1'b0; bus.hit_pulse = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // First six ticks after a seeded LFSR, hand-derived from 0xACE1.
  task automatic run_opening(input string tag);
    logic [N-1:0] exp_seq [6];
    exp_seq = '{5'b00001, 5'b00101, 5'b00101, 5'b00101, 5'b00100, 5'b10000};
    drive(1'b0, 1'b1, '0);
    check({tag, "_start_active"}, int'(bus.game_active), 1);
    check({tag, "_start_time"}, int'(bus.time_left), 60);
    check({tag, "_start_score"}, int'(bus.score), 0);
    check({tag, "_start_moles"}, int'(bus.mole_active), 0);
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, '0);
      check({tag, "_seq_moles"}, int'(bus.mole_active), int'(exp_seq[k]));
      check({tag, "_seq_time"}, int'(bus.time_left), 59 - k);
      if (k == 4) check({tag, "_first_miss"}, int'(bus.miss_count), 1);
    end
  endtask

  initial begin
    logic [N-1:0] h, prev, fresh;
    int sc, ms, ticks, j;
    bit found;
    bus.tick = 1'b0; bus.start = 1'b0; bus.hit_pulse = '0;
    @(posedge clk); #1;
    do_reset();
    chk_en = 1'b1;
    check("reset_active", int'(bus.game_active), 0);
    check("reset_time", int'(bus.time_left), 0);
    drive(1'b1, 1'b0, 5'b00001);
    check("idle_ignores_tick", int'(bus.time_left), 0);

    run_opening("g1");
    drive(1'b0, 1'b0, 5'b00001);
    check("wrong_at_zero", int'(bus.score), 0);
    drive(1'b0, 1'b0, 5'b10001);
    check("hit_plus_wrong_score", int'(bus.score), 0);
    check("hit_clears_mole", int'(bus.mole_active), 0);

    for (int k = 0; k < 45 && m_score < 8 && m_time > 1; k++) begin
      drive(1'b1, 1'b0, '0);
      h = lowest(model_mask());
      if (h != '0) drive(1'b0, 1'b0, h);
    end
    check("reached_score_8", m_score, 8);
    if (m_score == 8) begin
      check("level_at_8", int'(bus.level), 1);
      found = 1'b0; j = 0;
      for (int k = 0; k < 15 && !found && m_time > 6; k++) begin
        prev = model_mask();
        drive(1'b1, 1'b0, '0);
        fresh = bus.mole_active & ~prev;
        if (fresh != '0) begin
          found = 1'b1;
          for (int i = N - 1; i >= 0; i--) if (fresh[i]) j = i;
        end
      end
      check("level1_spawn_seen", int'(found), 1);
      if (found) begin
        ticks = 0;
        while (bus.mole_active[j] && ticks < 10) begin
          drive(1'b1, 1'b0, '0);
          ticks++;
        end
        check("level1_lifetime", ticks, 3);
      end
    end

    for (int k = 0; k < 70 && m_time > 1; k++) drive(1'b1, 1'b0, '0);
    h  = lowest(model_mask());
    sc = m_score + ((h != '0) ? 1 : 0);
    ms = m_miss;
    drive(1'b1, 1'b0, h);
    check("final_over", int'(bus.game_over), 1);
    check("final_time", int'(bus.time_left), 0);
    check("final_moles", int'(bus.mole_active), 0);
    check("final_hit_scored", int'(bus.score), sc);
    check("final_miss_same", int'(bus.miss_count), ms);
    drive(1'b1, 1'b0, 5'b11111);
    check("over_holds_score", int'(bus.score), sc);

    drive(1'b0, 1'b1, '0);
    check("restart_active", int'(bus.game_active), 1);
    check("restart_score", int'(bus.score), 0);
    check("restart_time", int'(bus.time_left), 60);
    for (int k = 0; k < 40 && m_time > 30; k++) begin
      drive(1'b1, 1'b0, '0);
      h = lowest(model_mask());
      if (m_score < 5 && h != '0) drive(1'b0, 1'b0, h);
    end
    check("mid_time_30", m_time, 30);
    do_reset();
    check("midreset_moles", int'(bus.mole_active), 0);
    check("midreset_score", int'(bus.score), 0);
    check("midreset_miss", int'(bus.miss_count), 0);
    check("midreset_level", int'(bus.level), 0);
    check("midreset_active", int'(bus.game_active), 0);
    check("midreset_over", int'(bus.game_over), 0);
    run_opening("g3");

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad_n);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad_n);
    $fatal(1, "watchdog");
  end
endmodule
